pipelined_addsub_seg: RTL and testbench

- Parametrised successor to the team's registered 64-bit fast add/sub.
- Splits the W-bit operation into SEG carry-pipelined segments, one segment resolved per stage, so W can grow without lengthening the critical path.
- Adds four per-transaction opcodes (add/sub, each with or without carry-in), signed-overflow and zero flags, and valid/ready flow control with backpressure.
- Sits between operand sources and result consumers in the datapath.

---
 rtl/pipelined_addsub_seg.sv | 139 +++++++++++++
 tb/tb_pipelined_addsub_seg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub_seg.sv
// W-bit add/sub split into SEG carry-pipelined segments; result after SEG+1 register levels.
// Global stall: every stage holds while a result sits unaccepted at the output (requires SEG >= 2).
module pipelined_addsub_seg #(
  parameter int W   = 64,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  localparam int SW = W / SEG;

  logic         w_adv;
  logic [W-1:0] w_bp;
  logic         w_c0;

  logic         r_cap_vld;
  logic [W-1:0] r_cap_a;
  logic [W-1:0] r_cap_b;
  logic         r_cap_c;

  // Stage k registers hold the result of resolving segment k
  logic         r_vld [SEG];
  logic [W-1:0] r_s   [SEG];
  logic         r_c   [SEG];
  logic [W-1:0] r_a   [SEG-1];
  logic [W-1:0] r_b   [SEG-1];
  logic         r_ovf;
  logic         r_zero;

  logic         w_in_vld [SEG];
  logic [W-1:0] w_in_a   [SEG];
  logic [W-1:0] w_in_b   [SEG];
  logic [W-1:0] w_in_s   [SEG];
  logic         w_in_c   [SEG];
  logic [SW:0]  w_seg    [SEG];
  logic [W-1:0] w_out_s  [SEG];
  logic         w_ovf;
  logic         w_zero;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_bp = op[0] ? ~b : b;
  assign w_c0 = op[1] ? (cin ^ op[0]) : op[0];

  always_comb begin
    w_in_vld[0] = r_cap_vld;
    w_in_a[0]   = r_cap_a;
    w_in_b[0]   = r_cap_b;
    w_in_c[0]   = r_cap_c;
    w_in_s[0]   = '0;
    for (int k = 1; k < SEG; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_c[k]   = r_c[k-1];
      w_in_s[k]   = r_s[k-1];
    end
  end

  // Each stage resolves one segment and passes the already-resolved low bits through
  always_comb begin
    for (int k = 0; k < SEG; k++) begin
      w_seg[k] = {1'b0, w_in_a[k][k*SW +: SW]} + {1'b0, w_in_b[k][k*SW +: SW]}
               + {{SW{1'b0}}, w_in_c[k]};
      w_out_s[k] = w_in_s[k];
      w_out_s[k][k*SW +: SW] = w_seg[k][SW-1:0];
    end
  end

  assign w_ovf  = (w_in_a[SEG-1][W-1] == w_in_b[SEG-1][W-1]) &
                  (w_out_s[SEG-1][W-1] != w_in_a[SEG-1][W-1]);
  assign w_zero = ~|w_out_s[SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_a   <= '0;
      r_cap_b   <= '0;
      r_cap_c   <= 1'b0;
      for (int k = 0; k < SEG; k++) begin
        r_vld[k] <= 1'b0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      for (int k = 0; k < SEG-1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_cap_vld <= in_valid;
      if (in_valid) begin
        r_cap_a <= a;
        r_cap_b <= w_bp;
        r_cap_c <= w_c0;
      end
      // Data registers only load behind a valid transaction; bubbles leave them untouched
      for (int k = 0; k < SEG; k++) begin
        r_vld[k] <= w_in_vld[k];
        if (w_in_vld[k]) begin
          r_s[k] <= w_out_s[k];
          r_c[k] <= w_seg[k][SW];
        end
      end
      for (int k = 0; k < SEG-1; k++) begin
        if (w_in_vld[k]) begin
          r_a[k] <= w_in_a[k];
          r_b[k] <= w_in_b[k];
        end
      end
      if (w_in_vld[SEG-1]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_vld[SEG-1];
  assign sum       = r_s[SEG-1];
  assign carry     = r_c[SEG-1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub_seg.sv
// Bench for pipelined_addsub_seg (W=64, SEG=4): directed cases plus a scoreboarded stream with a stall.
module tb_pipelined_addsub_seg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        carry;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t q[$];

  pipelined_addsub_seg #(.W(64), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic [1:0] mop, input logic mcin);
    exp_t        e;
    logic [63:0] bp;
    logic        c0;
    logic [64:0] r;
    bp = mop[0] ? ~mb : mb;
    case (mop)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      2'b10:   c0 = mcin;
      default: c0 = ~mcin;
    endcase
    r   = {1'b0, ma} + {1'b0, bp} + {64'd0, c0};
    e.s = r[63:0];
    e.c = r[64];
    e.v = (ma[63] == bp[63]) && (r[63] != ma[63]);
    e.z = (r[63:0] == 64'd0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transaction is accepted
  task automatic send(input logic [63:0] ta, input logic [63:0] tb,
                      input logic [1:0] top, input logic tcin);
    a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        q.push_back(model(ta, tb, top, tcin));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
  endtask

  // Single transaction into an empty pipeline; lat = negedges after the capture edge until out_valid
  task automatic run_one(input logic [63:0] ta, input logic [63:0] tb, input logic [1:0] top,
                         input logic tcin, output logic [63:0] rs, output logic rc,
                         output logic rv, output logic rz, output int lat);
    a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; rs = '0; rc = 1'b0; rv = 1'b0; rz = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        rs = sum; rc = carry; rv = overflow; rz = zero; lat = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL reset_sum: got %h required 0", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b required 0", carry); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b required 0", zero); end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple;
    logic [63:0] s; logic c, v, z; int lat;
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, s, c, v, z, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency: got %0d required 4", lat); end
    checks++; if (s !== 64'd0) begin errors++; $display("FAIL ripple_sum: got %h required 0", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ripple_carry: got %b required 1", c); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL ripple_zero: got %b required 1", z); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL ripple_overflow: got %b required 0", v); end
  endtask

  task automatic test_sub_borrow;
    logic [63:0] s; logic c, v, z; int lat;
    run_one(64'd5, 64'd7, 2'b01, 1'b0, s, c, v, z, lat);
    checks++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_sum: got %h required fffffffffffffffe", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b required 0", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL sub_overflow: got %b required 0", v); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d required 4", lat); end
    run_one(64'd10, 64'd3, 2'b11, 1'b1, s, c, v, z, lat);
    checks++; if (s !== 64'd6) begin errors++; $display("FAIL sbb_sum: got %h required 6", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sbb_carry: got %b required 1", c); end
  endtask

  task automatic test_overflow_cin;
    logic [63:0] s; logic c, v, z; int lat;
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, s, c, v, z, lat);
    checks++; if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum: got %h required 8000000000000000", s); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_overflow: got %b required 1", v); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_carry: got %b required 0", c); end
    run_one(64'd0, 64'd0, 2'b10, 1'b1, s, c, v, z, lat);
    checks++; if (s !== 64'd1) begin errors++; $display("FAIL adc_sum: got %h required 1", s); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL adc_zero: got %b required 0", z); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL adc_carry: got %b required 0", c); end
  endtask

  task automatic test_back_to_back;
    int          got;
    int          stalled;
    logic [63:0] prev_sum;
    logic        prev_stall;
    exp_t        e;
    got = 0; stalled = 0; prev_sum = '0; prev_stall = 1'b0;
    q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'(i), 64'(i), 2'b00, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 100 && got < 8; n++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== (~out_valid | out_ready)) begin
            errors++; $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
          end
          if (out_valid && !out_ready) begin
            stalled++;
            if (prev_stall) begin
              checks++;
              if (sum !== prev_sum) begin errors++; $display("FAIL bp_hold_sum: got %h required %h", sum, prev_sum); end
            end
            prev_stall = 1'b1;
            prev_sum   = sum;
          end else begin
            prev_stall = 1'b0;
          end
          if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++; $display("FAIL bp_extra_result: got %h required none", sum);
            end else begin
              e = q.pop_front();
              if (sum !== e.s || carry !== e.c || overflow !== e.v || zero !== e.z) begin
                errors++; $display("FAIL bp_result: got %h/%b%b%b required %h/%b%b%b", sum, carry, overflow, zero, e.s, e.c, e.v, e.z);
              end
              checks++;
              if (sum !== 64'(2 * got)) begin errors++; $display("FAIL bp_order: got %h required %h", sum, 64'(2 * got)); end
            end
            got++;
          end
        end
      end
    join
    checks++; if (got !== 8) begin errors++; $display("FAIL bp_count: got %0d required 8", got); end
    checks++; if (stalled !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d required 3", stalled); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d required 0", q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] s; logic c, v, z; int lat; logic stale;
    for (int i = 0; i < 3; i++) send(64'(100 + i), 64'd1, 2'b00, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b required 0", out_valid); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL mid_sum_clear: got %h required 0", sum); end
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    stale = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale: got out_valid after reset, required none"); end
    @(posedge clk); #1;
    run_one(64'd123, 64'd77, 2'b00, 1'b0, s, c, v, z, lat);
    checks++; if (s !== 64'd200) begin errors++; $display("FAIL mid_next_sum: got %h required c8", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_next_latency: got %0d required 4", lat); end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_sub_borrow();
    test_overflow_cin();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
